// File: rtl/ahb_lite_bus_arbiter.sv
// ahb_lite_bus_arbiter: round-robin sharing of one AHB-Lite slave port among NUM_MASTERS masters
module ahb_lite_bus_arbiter #(
   parameter int NUM_MASTERS = 4,
   parameter int ADDR_W      = 32,
   parameter int DATA_W      = 32,
   parameter int MAX_HOLD    = 8
) (
   input  logic                          HCLK,
   input  logic                          HRESETIN,
   input  logic [NUM_MASTERS-1:0]        HBUSREQ,
   input  logic [2*NUM_MASTERS-1:0]      M_HTRANS,
   input  logic [NUM_MASTERS-1:0]        M_HWRITE,
   input  logic [2*NUM_MASTERS-1:0]      M_HSIZE,
   input  logic [ADDR_W*NUM_MASTERS-1:0] M_HADDR,
   input  logic [DATA_W*NUM_MASTERS-1:0] M_HWDATA,
   input  logic                          HREADYOUT,
   output logic [NUM_MASTERS-1:0]        HGRANT,
   output logic [$clog2(NUM_MASTERS)-1:0] HMASTER,
   output logic                          HREADY,
   output logic                          HSELX,
   output logic                          HWRITE,
   output logic [1:0]                    HTRANS,
   output logic [1:0]                    HSIZE,
   output logic [ADDR_W-1:0]             HADDR,
   output logic [DATA_W-1:0]             HWDATA
);
   localparam int IW = $clog2(NUM_MASTERS);
   localparam logic [7:0] MAX_H = 8'(MAX_HOLD);
   typedef enum logic {IDLE, GRANTED} state_t;
   state_t                 state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d, others, cand;
   logic [IW-1:0]          hmaster_q, hmaster_d, dmaster_q, dmaster_d, rr_q, rr_d, win;
   logic [7:0]             hold_q, hold_d, hold_inc;
   logic                   busy, acc, owner_req, rearb;

   // first requester strictly after the pointer, wrapping around
   function automatic logic [IW-1:0] rr_pick(input logic [NUM_MASTERS-1:0] req, input logic [IW-1:0] ptr);
      rr_pick = ptr;
      for (int k = NUM_MASTERS; k >= 1; k--) begin
         int idx;
         idx = (int'(ptr) + k) % NUM_MASTERS;
         if (req[idx]) rr_pick = IW'(idx);
      end
   endfunction

   assign busy   = state_q == GRANTED;
   assign HGRANT = grant_q;
   assign HMASTER = hmaster_q;
   assign HREADY = HREADYOUT;
   assign HTRANS = busy ? M_HTRANS[2*hmaster_q +: 2] : 2'b00;
   assign HWRITE = busy ? M_HWRITE[hmaster_q] : 1'b0;
   assign HSIZE  = busy ? M_HSIZE[2*hmaster_q +: 2] : 2'b00;
   assign HADDR  = busy ? M_HADDR[ADDR_W*hmaster_q +: ADDR_W] : '0;
   assign HSELX  = HTRANS[1];
   assign HWDATA = M_HWDATA[DATA_W*dmaster_q +: DATA_W];

   // arbitration decision and data-phase tracking for the next edge
   always_comb begin
      state_d   = state_q;
      grant_d   = grant_q;
      hmaster_d = hmaster_q;
      dmaster_d = dmaster_q;
      hold_d    = hold_q;
      rr_d      = rr_q;
      acc       = HTRANS[1] & HREADYOUT;
      hold_inc  = (hold_q == 8'hff) ? hold_q : hold_q + {7'd0, acc};
      others    = HBUSREQ & ~grant_q;
      owner_req = |(HBUSREQ & grant_q);
      rearb     = busy ? HREADYOUT & (~owner_req | (hold_inc >= MAX_H && |others)) : |HBUSREQ;
      cand      = (busy && owner_req) ? others : HBUSREQ;
      win       = rr_pick(cand, rr_q);
      if (acc) dmaster_d = hmaster_q;
      if (busy && HREADYOUT) hold_d = hold_inc;
      if (rearb) begin
         state_d   = |cand ? GRANTED : IDLE;
         grant_d   = |cand ? {{(NUM_MASTERS-1){1'b0}}, 1'b1} << win : '0;
         hmaster_d = |cand ? win : hmaster_q;
         rr_d      = |cand ? win : rr_q;
         hold_d    = 8'd0;
      end
   end

   // arbiter state registers, reset abandons any in-flight transfer
   always_ff @(posedge HCLK or posedge HRESETIN) begin
      if (HRESETIN) begin
         state_q   <= IDLE;
         grant_q   <= '0;
         hmaster_q <= '0;
         dmaster_q <= '0;
         hold_q    <= '0;
         rr_q      <= IW'(NUM_MASTERS - 1);
      end else begin
         state_q   <= state_d;
         grant_q   <= grant_d;
         hmaster_q <= hmaster_d;
         dmaster_q <= dmaster_d;
         hold_q    <= hold_d;
         rr_q      <= rr_d;
      end
   end
endmodule

// File: tb/tb_ahb_lite_bus_arbiter.sv
// tb_ahb_lite_bus_arbiter: directed and randomized checks against a behavioural arbiter model
module tb_ahb_lite_bus_arbiter;
   localparam int N = 4, AW = 32, DW = 32, MH = 4;
   logic            HCLK = 1'b0, HRESETIN, HREADYOUT;
   logic [N-1:0]    HBUSREQ, M_HWRITE, HGRANT;
   logic [2*N-1:0]  M_HTRANS, M_HSIZE;
   logic [AW*N-1:0] M_HADDR;
   logic [DW*N-1:0] M_HWDATA;
   logic [1:0]      HMASTER, HTRANS, HSIZE;
   logic            HREADY, HSELX, HWRITE;
   logic [AW-1:0]   HADDR;
   logic [DW-1:0]   HWDATA;
   int checks = 0, errors = 0;
   int own, hm, dm, hold, ptr;

   ahb_lite_bus_arbiter #(.NUM_MASTERS(N), .ADDR_W(AW), .DATA_W(DW), .MAX_HOLD(MH)) dut (
      .HCLK(HCLK), .HRESETIN(HRESETIN), .HBUSREQ(HBUSREQ), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE),
      .M_HSIZE(M_HSIZE), .M_HADDR(M_HADDR), .M_HWDATA(M_HWDATA), .HREADYOUT(HREADYOUT), .HGRANT(HGRANT),
      .HMASTER(HMASTER), .HREADY(HREADY), .HSELX(HSELX), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
      .HADDR(HADDR), .HWDATA(HWDATA));

   always #5 HCLK = ~HCLK;

   function automatic int pick(input logic [N-1:0] req, input int p);
      for (int k = 1; k <= N; k++) if (req[(p + k) % N]) return (p + k) % N;
      return -1;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      own = -1; hm = 0; dm = 0; hold = 0; ptr = N - 1;
   endtask

   task automatic check_all();
      logic [N-1:0] eg;
      logic [1:0] et, es;
      logic ew;
      logic [AW-1:0] ea;
      eg = '0; et = 2'b00; es = 2'b00; ew = 1'b0; ea = '0;
      if (own >= 0) begin
         eg[own] = 1'b1;
         et = M_HTRANS[2*hm +: 2]; es = M_HSIZE[2*hm +: 2]; ew = M_HWRITE[hm]; ea = M_HADDR[AW*hm +: AW];
      end
      chk("HGRANT", HGRANT, eg);
      chk("HMASTER", HMASTER, hm);
      chk("HTRANS", HTRANS, et);
      chk("HSELX", HSELX, et[1]);
      chk("HWRITE", HWRITE, ew);
      chk("HSIZE", HSIZE, es);
      chk("HADDR", HADDR, ea);
      chk("HWDATA", HWDATA, M_HWDATA[DW*dm +: DW]);
      chk("HREADY", HREADY, HREADYOUT);
   endtask

   task automatic model_step();
      int h, nxt;
      logic [N-1:0] oth;
      if (own < 0) begin
         if (HBUSREQ != 0) begin own = pick(HBUSREQ, ptr); hm = own; ptr = own; hold = 0; end
      end else if (HREADYOUT) begin
         h = hold;
         if (M_HTRANS[2*hm+1]) begin dm = hm; h = (hold == 255) ? 255 : hold + 1; end
         oth = HBUSREQ; oth[own] = 1'b0;
         nxt = -2;
         if (!HBUSREQ[own]) nxt = pick(HBUSREQ, ptr);
         else if (h >= MH && oth != 0) nxt = pick(oth, ptr);
         if (nxt == -2) hold = h;
         else begin
            hold = 0; own = nxt;
            if (nxt >= 0) begin hm = nxt; ptr = nxt; end
         end
      end
   endtask

   task automatic cycle();
      @(negedge HCLK);
      check_all();
      model_step();
      @(posedge HCLK);
      #1;
   endtask

   task automatic idle_inputs();
      HBUSREQ = '0; M_HTRANS = '0; M_HWRITE = '0; M_HSIZE = '0; M_HADDR = '0; HREADYOUT = 1'b1;
      for (int i = 0; i < N; i++) M_HWDATA[DW*i +: DW] = 32'hD000_0000 + i;
   endtask

   task automatic do_reset();
      idle_inputs();
      HRESETIN = 1'b1;
      @(posedge HCLK);
      #1;
      HRESETIN = 1'b0;
      model_reset();
      chk("rst_grant", HGRANT, 0);
      chk("rst_hmaster", HMASTER, 0);
      chk("rst_htrans", HTRANS, 0);
      chk("rst_hselx", HSELX, 0);
   endtask

   initial begin
      logic [N-1:0] mask, last;
      int order[$];
      int cnt, o;
      logic accd;
      // 1: single request, grant one cycle later, address mux
      do_reset();
      HBUSREQ = 4'b0100;
      cycle();
      chk("t1_grant", HGRANT, 4'b0100);
      chk("t1_hmaster", HMASTER, 2);
      M_HADDR[AW*2 +: AW] = 32'h1000;
      M_HTRANS[5:4] = 2'b10;
      #1;
      chk("t1_haddr", HADDR, 32'h1000);
      chk("t1_hselx", HSELX, 1);
      cycle();
      // 2: everyone requests, each drops after one transfer
      do_reset();
      mask = 4'hF; last = '0;
      HBUSREQ = mask;
      for (int i = 0; i < N; i++) M_HTRANS[2*i +: 2] = 2'b10;
      for (int c = 0; c < 40; c++) begin
         o = own;
         accd = own >= 0 && HREADYOUT && M_HTRANS[2*hm+1];
         cycle();
         if (HGRANT != 0 && HGRANT != last) order.push_back(int'(HGRANT));
         last = HGRANT;
         if (accd) begin mask[o] = 1'b0; M_HTRANS[2*o +: 2] = 2'b00; end
         HBUSREQ = mask;
         if (mask == 0 && HGRANT == 0) break;
      end
      chk("t2_order_len", order.size(), 4);
      for (int i = 0; i < order.size() && i < 4; i++) chk("t2_order", order[i], 1 << i);
      chk("t2_idle", HGRANT, 0);
      // 3: hold limit with a competing requester
      do_reset();
      HBUSREQ = 4'b0011;
      M_HTRANS[1:0] = 2'b10;
      cnt = 0;
      for (int c = 0; c < 30; c++) begin
         if (HGRANT == 4'b0001 && HTRANS[1] && HREADYOUT) cnt++;
         cycle();
         if (HGRANT == 4'b0010) break;
      end
      chk("t3_count", cnt, MH);
      chk("t3_grant", HGRANT, 4'b0010);
      // 4: wait states freeze grant and data-phase master
      do_reset();
      HBUSREQ = 4'b0010;
      M_HTRANS[3:2] = 2'b10; M_HWRITE[1] = 1'b1; M_HWDATA[DW +: DW] = 32'hAAAA_1111;
      cycle();
      cycle();
      HBUSREQ = 4'b0100; HREADYOUT = 1'b0;
      for (int c = 0; c < 3; c++) begin
         cycle();
         chk("t4_grant", HGRANT, 4'b0010);
         chk("t4_hwdata", HWDATA, 32'hAAAA_1111);
      end
      HREADYOUT = 1'b1;
      cycle();
      chk("t4_regrant", HGRANT, 4'b0100);
      // 5: handover 0->3 overlapping data and address phases
      do_reset();
      HBUSREQ = 4'b0001;
      M_HTRANS[1:0] = 2'b10; M_HWRITE[0] = 1'b1; M_HWDATA[DW-1:0] = 32'h0BAD_F00D;
      M_HTRANS[7:6] = 2'b10; M_HADDR[AW*3 +: AW] = 32'h3000_0040;
      cycle();
      HBUSREQ = 4'b1000;
      cycle();
      chk("t5_grant", HGRANT, 4'b1000);
      chk("t5_haddr", HADDR, 32'h3000_0040);
      chk("t5_hwdata", HWDATA, 32'h0BAD_F00D);
      cycle();
      // 6: asynchronous reset mid-burst
      do_reset();
      HBUSREQ = 4'b0110;
      M_HTRANS = 8'b1010_1010;
      for (int c = 0; c < 3; c++) cycle();
      #2;
      HRESETIN = 1'b1;
      #1;
      chk("t6_grant", HGRANT, 0);
      chk("t6_htrans", HTRANS, 0);
      chk("t6_hselx", HSELX, 0);
      model_reset();
      @(posedge HCLK);
      #1;
      HRESETIN = 1'b0;
      HBUSREQ = 4'b1111;
      cycle();
      chk("t6_first", HGRANT, 4'b0001);
      // randomized traffic against the model
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            int r;
            if ($urandom_range(0, 5) == 0) HBUSREQ[i] = ~HBUSREQ[i];
            r = $urandom_range(0, 9);
            M_HTRANS[2*i +: 2] = r < 2 ? 2'b00 : (r < 8 ? 2'b10 : 2'b11);
            M_HWRITE[i] = 1'($urandom);
            M_HSIZE[2*i +: 2] = 2'($urandom);
            M_HADDR[AW*i +: AW] = $urandom;
            M_HWDATA[DW*i +: DW] = $urandom;
         end
         HREADYOUT = $urandom_range(0, 3) != 0;
         cycle();
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
